// File: rtl/fir_tap_loader.sv
// Coefficient programming sequencer for fir_filter: streams host coefficients into the tap
// memory with the filter disabled, optionally expanding a half set into a symmetric response.
module fir_tap_loader #(
    parameter int unsigned ORDER          = 50,
    parameter int unsigned TAP_DATA_WIDTH = 16,
    parameter int unsigned TAP_ADDR_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_run_req,
    input  logic                      i_start,
    input  logic                      i_sym,
    input  logic                      i_abort,
    input  logic                      i_coef_valid,
    input  logic [TAP_DATA_WIDTH-1:0] i_coef_data,
    output logic                      o_coef_ready,
    output logic                      o_fir_en,
    output logic                      o_tap_wr_en,
    output logic [TAP_ADDR_WIDTH-1:0] o_tap_wr_addr,
    output logic [TAP_DATA_WIDTH-1:0] o_tap_wr_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);

    typedef enum logic [2:0] {StIdle, StQuiesce, StLoad, StMirror, StFlush} state_e;

    localparam logic [TAP_ADDR_WIDTH-1:0] LastAddr = TAP_ADDR_WIDTH'(ORDER);
    localparam logic [TAP_ADDR_WIDTH-1:0] HalfAddr = TAP_ADDR_WIDTH'(ORDER / 2);

    state_e                    state_q, state_d;
    logic [TAP_ADDR_WIDTH-1:0] k_q, k_d;
    logic [TAP_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TAP_DATA_WIDTH-1:0] coef_q, coef_d;
    logic [TAP_DATA_WIDTH-1:0] data_q, data_d;
    logic                      sym_q, sym_d;
    logic                      fir_en_q, fir_en_d;
    logic                      wr_en_q, wr_en_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [TAP_ADDR_WIDTH-1:0] mirror_addr;

    assign mirror_addr  = LastAddr - k_q;
    assign o_coef_ready = (state_q == StLoad) && !i_abort;
    assign o_busy       = (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        addr_d   = addr_q;
        coef_d   = coef_q;
        data_d   = data_q;
        sym_d    = sym_q;
        fir_en_d = fir_en_q;
        wr_en_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // Abort wins over everything, including a pending mirror write.
        if (state_q != StIdle && i_abort) begin
            state_d  = StIdle;
            err_d    = 1'b1;
            fir_en_d = i_run_req;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_d  = StQuiesce;
                        fir_en_d = 1'b0;
                        sym_d    = i_sym;
                    end else begin
                        fir_en_d = i_run_req;
                    end
                end
                StQuiesce: begin
                    state_d = StLoad;
                    k_d     = '0;
                end
                StLoad: begin
                    if (i_coef_valid) begin
                        wr_en_d = 1'b1;
                        addr_d  = k_q;
                        data_d  = i_coef_data;
                        coef_d  = i_coef_data;
                        if (sym_q) begin
                            // Centre tap of an even order has no mirror partner.
                            state_d = (mirror_addr != k_q) ? StMirror : StFlush;
                        end else if (k_q == LastAddr) begin
                            state_d = StFlush;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                StMirror: begin
                    wr_en_d = 1'b1;
                    addr_d  = mirror_addr;
                    data_d  = coef_q;
                    if (k_q == HalfAddr) begin
                        state_d = StFlush;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = StLoad;
                    end
                end
                StFlush: begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    fir_en_d = i_run_req;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            k_q      <= '0;
            addr_q   <= '0;
            coef_q   <= '0;
            data_q   <= '0;
            sym_q    <= 1'b0;
            fir_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            coef_q   <= coef_d;
            data_q   <= data_d;
            sym_q    <= sym_d;
            fir_en_q <= fir_en_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_fir_en      = fir_en_q;
    assign o_tap_wr_en   = wr_en_q;
    assign o_tap_wr_addr = addr_q;
    assign o_tap_wr_data = data_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule
